// File: rtl/mem_dbus_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory/bridge (slave).
// A transaction is held by the master from req rising until the slave returns ack.
interface mem_dbus_stage_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ack, err, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ack, err, rdata
  );
endinterface

// File: rtl/mem_dbus_stage.sv
// MiniMIPS32 memory-access stage: drives the req/ack data bus, stalls until completion, aligns loads.
// Optional build macro MEM_ADDR_EXC_EN raises AdEL/AdES on misaligned halfword/word accesses.
module mem_dbus_stage (
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst,
  input  logic                 flush,

  input  logic [7:0]           mem_aluop,
  input  logic [4:0]           mem_wa,
  input  logic                 mem_wreg,
  input  logic                 mem_mreg,
  input  logic                 mem_whilo,
  input  logic [63:0]          mem_hilo,
  input  logic [31:0]          mem_wd,
  input  logic [31:0]          mem_din,
  input  logic                 mem_cp0_we,
  input  logic [4:0]           mem_cp0_waddr,
  input  logic [31:0]          mem_cp0_wdata,
  input  logic [31:0]          mem_pc,
  input  logic                 mem_in_delay,
  input  logic [4:0]           mem_exccode,

  mem_dbus_stage_if.master     dbus,

  output logic                 stall_req,
  output logic [4:0]           wb_wa,
  output logic                 wb_wreg,
  output logic                 wb_whilo,
  output logic [63:0]          wb_hilo,
  output logic                 wb_cp0_we,
  output logic [4:0]           wb_cp0_waddr,
  output logic [31:0]          wb_cp0_wdata,
  output logic [31:0]          wb_wd,
  output logic [4:0]           wb_exccode,
  output logic [31:0]          wb_badvaddr,
  output logic [31:0]          wb_pc,
  output logic                 wb_in_delay
);

  localparam logic [7:0] MINIMIPS32_LB  = 8'h90;
  localparam logic [7:0] MINIMIPS32_LBU = 8'h91;
  localparam logic [7:0] MINIMIPS32_LH  = 8'h92;
  localparam logic [7:0] MINIMIPS32_LHU = 8'h93;
  localparam logic [7:0] MINIMIPS32_LW  = 8'h94;
  localparam logic [7:0] MINIMIPS32_SB  = 8'h98;
  localparam logic [7:0] MINIMIPS32_SH  = 8'h99;
  localparam logic [7:0] MINIMIPS32_SW  = 8'h9A;

  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_BUS  = 5'h07;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic        killed;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        is_ld, is_st, is_mem, is_half, is_word;
  logic [1:0]  a, eff_a;
  logic        in_exc, adr_exc, bus_err, kill_wb, go, req;
  logic [4:0]  adr_code;
  logic        live_we;
  logic [3:0]  live_be;
  logic [31:0] live_addr, live_wdata, ld_data;

  // mem_mreg is carried by the pipeline but this stage derives load-ness from the micro-op.
  logic unused_mreg;
  assign unused_mreg = mem_mreg;

  assign is_ld   = mem_aluop inside {MINIMIPS32_LB, MINIMIPS32_LBU, MINIMIPS32_LH,
                                     MINIMIPS32_LHU, MINIMIPS32_LW};
  assign is_st   = mem_aluop inside {MINIMIPS32_SB, MINIMIPS32_SH, MINIMIPS32_SW};
  assign is_mem  = is_ld | is_st;
  assign is_half = mem_aluop inside {MINIMIPS32_LH, MINIMIPS32_LHU, MINIMIPS32_SH};
  assign is_word = mem_aluop inside {MINIMIPS32_LW, MINIMIPS32_SW};
  assign a       = mem_wd[1:0];
  assign in_exc  = (mem_exccode != EXC_NONE);

`ifdef MEM_ADDR_EXC_EN
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  assign adr_exc  = (is_half && a[0]) || (is_word && (a != 2'b00));
  assign adr_code = is_ld ? EXC_ADEL : EXC_ADES;
`else
  assign adr_exc  = 1'b0;
  assign adr_code = EXC_NONE;
`endif

  // Misaligned low bits are dropped; with address exceptions enabled those ops never issue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    eff_a = a;
    if (is_word)      eff_a = 2'b00;
    else if (is_half) eff_a = {a[1], 1'b0};
  end

  assign go        = is_mem && !in_exc && !adr_exc && !flush && !cpu_rst;
  assign req       = ((state == S_IDLE) && go) || ((state == S_WAIT) && !cpu_rst);
  assign stall_req = is_mem && !in_exc && !adr_exc && (state != S_DONE) && !flush && !cpu_rst;

  assign live_we   = is_st;
  assign live_addr = {mem_wd[31:2], 2'b00};

  always_comb begin
    live_be    = 4'h0;
    live_wdata = 32'h0;
    case (mem_aluop)
      MINIMIPS32_LB, MINIMIPS32_LBU: live_be = 4'b0001 << eff_a;
      MINIMIPS32_LH, MINIMIPS32_LHU: live_be = 4'b0011 << eff_a;
      MINIMIPS32_LW:                 live_be = 4'hF;
      MINIMIPS32_SB: begin
        live_be    = 4'b0001 << eff_a;
        live_wdata = {4{mem_din[7:0]}};
      end
      MINIMIPS32_SH: begin
        live_be    = 4'b0011 << eff_a;
        live_wdata = {2{mem_din[15:0]}};
      end
      MINIMIPS32_SW: begin
        live_be    = 4'hF;
        live_wdata = mem_din;
      end
      default: ;
    endcase
  end

  // Live fields cover the issue cycle (zero-wait ack); the captured copy covers WAIT,
  // because a flush may clear the EXE/MEM register while the transaction is outstanding.
  always_comb begin
    dbus.req   = req;
    dbus.we    = 1'b0;
    dbus.be    = 4'h0;
    dbus.addr  = 32'h0;
    dbus.wdata = 32'h0;
    if (req) begin
      if (state == S_WAIT) begin
        dbus.we    = we_q;
        dbus.be    = be_q;
        dbus.addr  = addr_q;
        dbus.wdata = wdata_q;
      end else begin
        dbus.we    = live_we;
        dbus.be    = live_be;
        dbus.addr  = live_addr;
        dbus.wdata = live_wdata;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (cpu_rst) begin
      state   <= S_IDLE;
      killed  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      if (req && dbus.ack) begin
        rdata_q <= dbus.rdata;
        err_q   <= dbus.err;
      end
      case (state)
        S_IDLE: begin
          if (go) begin
            we_q    <= live_we;
            be_q    <= live_be;
            addr_q  <= live_addr;
            wdata_q <= live_wdata;
            state   <= dbus.ack ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush)    killed <= 1'b1;
          if (dbus.ack) state  <= S_DONE;
        end
        S_DONE: begin
          killed <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_data = rdata_q;
    case (mem_aluop)
      MINIMIPS32_LB, MINIMIPS32_LBU: begin
        case (eff_a)
          2'd0:    ld_data = {24'h0, rdata_q[7:0]};
          2'd1:    ld_data = {24'h0, rdata_q[15:8]};
          2'd2:    ld_data = {24'h0, rdata_q[23:16]};
          default: ld_data = {24'h0, rdata_q[31:24]};
        endcase
        if (mem_aluop == MINIMIPS32_LB) ld_data[31:8] = {24{ld_data[7]}};
      end
      MINIMIPS32_LH, MINIMIPS32_LHU: begin
        ld_data = eff_a[1] ? {16'h0, rdata_q[31:16]} : {16'h0, rdata_q[15:0]};
        if (mem_aluop == MINIMIPS32_LH) ld_data[31:16] = {16{ld_data[15]}};
      end
      default: ;
    endcase
  end

  // Bus error and kill only apply in DONE, while the completing op is still presented on mem_*.
  assign bus_err = (state == S_DONE) && is_mem && err_q && !killed;
  assign kill_wb = (state == S_DONE) && killed;

  always_comb begin
    wb_exccode  = EXC_NONE;
    wb_badvaddr = 32'h0;
    if (in_exc) begin
      wb_exccode = mem_exccode;
    end else if (adr_exc) begin
      wb_exccode  = adr_code;
      wb_badvaddr = mem_wd;
    end else if (bus_err) begin
      wb_exccode  = EXC_BUS;
      wb_badvaddr = mem_wd;
    end
  end

  assign wb_wa        = mem_wa;
  assign wb_wreg      = mem_wreg   && (wb_exccode == EXC_NONE) && !kill_wb;
  assign wb_whilo     = mem_whilo  && (wb_exccode == EXC_NONE) && !kill_wb;
  assign wb_cp0_we    = mem_cp0_we && (wb_exccode == EXC_NONE) && !kill_wb;
  assign wb_hilo      = mem_hilo;
  assign wb_cp0_waddr = mem_cp0_waddr;
  assign wb_cp0_wdata = mem_cp0_wdata;
  assign wb_wd        = is_ld ? ld_data : mem_wd;
  assign wb_pc        = mem_pc;
  assign wb_in_delay  = mem_in_delay;

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Directed bench for mem_dbus_stage: reset, wait-state loads, stores, extension, flush, bus error.
// Build with MEM_ADDR_EXC_EN defined to exercise the address-exception variant.
module tb_mem_dbus_stage;

  localparam logic [7:0] NOP = 8'h00;
  localparam logic [7:0] LB  = 8'h90;
  localparam logic [7:0] LBU = 8'h91;
  localparam logic [7:0] LH  = 8'h92;
  localparam logic [7:0] LW  = 8'h94;
  localparam logic [7:0] SB  = 8'h98;
  localparam logic [7:0] SH  = 8'h99;
  localparam logic [7:0] SW  = 8'h9A;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_BUS  = 5'h07;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst, flush;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_wa, mem_cp0_waddr, mem_exccode;
  logic        mem_wreg, mem_mreg, mem_whilo, mem_cp0_we, mem_in_delay;
  logic [63:0] mem_hilo;
  logic [31:0] mem_wd, mem_din, mem_cp0_wdata, mem_pc;
  logic        stall_req, wb_wreg, wb_whilo, wb_cp0_we, wb_in_delay;
  logic [4:0]  wb_wa, wb_cp0_waddr, wb_exccode;
  logic [63:0] wb_hilo;
  logic [31:0] wb_cp0_wdata, wb_wd, wb_badvaddr, wb_pc;

  int checks = 0;
  int errors = 0;

  mem_dbus_stage_if dbus ();

  mem_dbus_stage dut (
    .cpu_clk_50M   (cpu_clk_50M),
    .cpu_rst       (cpu_rst),
    .flush         (flush),
    .mem_aluop     (mem_aluop),
    .mem_wa        (mem_wa),
    .mem_wreg      (mem_wreg),
    .mem_mreg      (mem_mreg),
    .mem_whilo     (mem_whilo),
    .mem_hilo      (mem_hilo),
    .mem_wd        (mem_wd),
    .mem_din       (mem_din),
    .mem_cp0_we    (mem_cp0_we),
    .mem_cp0_waddr (mem_cp0_waddr),
    .mem_cp0_wdata (mem_cp0_wdata),
    .mem_pc        (mem_pc),
    .mem_in_delay  (mem_in_delay),
    .mem_exccode   (mem_exccode),
    .dbus          (dbus),
    .stall_req     (stall_req),
    .wb_wa         (wb_wa),
    .wb_wreg       (wb_wreg),
    .wb_whilo      (wb_whilo),
    .wb_hilo       (wb_hilo),
    .wb_cp0_we     (wb_cp0_we),
    .wb_cp0_waddr  (wb_cp0_waddr),
    .wb_cp0_wdata  (wb_cp0_wdata),
    .wb_wd         (wb_wd),
    .wb_exccode    (wb_exccode),
    .wb_badvaddr   (wb_badvaddr),
    .wb_pc         (wb_pc),
    .wb_in_delay   (wb_in_delay)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic next_cycle;
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic clear_inputs;
    flush = 1'b0; mem_aluop = NOP; mem_wa = 5'd0; mem_wreg = 1'b0; mem_mreg = 1'b0;
    mem_whilo = 1'b0; mem_hilo = 64'h0; mem_wd = 32'h0; mem_din = 32'h0;
    mem_cp0_we = 1'b0; mem_cp0_waddr = 5'd0; mem_cp0_wdata = 32'h0;
    mem_pc = 32'h0; mem_in_delay = 1'b0; mem_exccode = EXC_NONE;
    dbus.ack = 1'b0; dbus.err = 1'b0; dbus.rdata = 32'h0;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] wd,
                        input logic [31:0] din, input logic wreg);
    mem_aluop = op; mem_wd = wd; mem_din = din; mem_wreg = wreg; mem_wa = 5'd9;
  endtask

  task automatic test_reset;
    cpu_rst = 1'b1;
    clear_inputs();
    set_op(LW, 32'h100, 32'h0, 1'b1);
    next_cycle();
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", dbus.req); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall_req); end
    checks++; if ({dbus.we, dbus.be, dbus.addr, dbus.wdata} !== 69'h0) begin errors++;
      $display("FAIL rst_bus got we=%b be=%h addr=%h wdata=%h exp zeros", dbus.we, dbus.be, dbus.addr, dbus.wdata); end
    checks++; if (wb_exccode !== EXC_NONE) begin errors++; $display("FAIL rst_exc got %h exp %h", wb_exccode, EXC_NONE); end
    next_cycle();
    cpu_rst = 1'b0;
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_lw_wait;
    int stalls = 0;
    set_op(LW, 32'h100, 32'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      dbus.ack   = (c == 2);
      dbus.rdata = (c == 2) ? 32'hDEADBEEF : 32'h0;
      @(negedge cpu_clk_50M);
      if (stall_req === 1'b1) stalls++;
      checks++; if (dbus.req !== 1'b1 || dbus.addr !== 32'h100 || dbus.be !== 4'hF || dbus.we !== 1'b0) begin errors++;
        $display("FAIL lw_bus c=%0d got req=%b addr=%h be=%h we=%b exp 1/100/f/0", c, dbus.req, dbus.addr, dbus.be, dbus.we); end
      next_cycle();
    end
    dbus.ack = 1'b0;
    @(negedge cpu_clk_50M);
    checks++; if (stalls != 3) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 3", stalls); end
    checks++; if (stall_req !== 1'b0 || dbus.req !== 1'b0) begin errors++;
      $display("FAIL lw_done got stall=%b req=%b exp 0/0", stall_req, dbus.req); end
    checks++; if (wb_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", wb_wd); end
    checks++; if (wb_wreg !== 1'b1 || wb_wa !== 5'd9) begin errors++;
      $display("FAIL lw_wreg got wreg=%b wa=%0d exp 1/9", wb_wreg, wb_wa); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_sb_zero_wait;
    set_op(SB, 32'h203, 32'h12345678, 1'b0);
    dbus.ack = 1'b1;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", dbus.be); end
    checks++; if (dbus.wdata !== 32'h78787878) begin errors++; $display("FAIL sb_wdata got %h exp 78787878", dbus.wdata); end
    checks++; if (dbus.we !== 1'b1 || dbus.addr !== 32'h200 || stall_req !== 1'b1) begin errors++;
      $display("FAIL sb_issue got we=%b addr=%h stall=%b exp 1/200/1", dbus.we, dbus.addr, stall_req); end
    next_cycle();
    dbus.ack = 1'b0;
    @(negedge cpu_clk_50M);
    checks++; if (stall_req !== 1'b0 || dbus.req !== 1'b0) begin errors++;
      $display("FAIL sb_done got stall=%b req=%b exp 0/0", stall_req, dbus.req); end
    next_cycle();
    clear_inputs();
  endtask

  // LB then LBU back to back: the second request must appear in the first IDLE after DONE.
  task automatic test_back_to_back;
    set_op(LB, 32'h001, 32'h0, 1'b1);
    dbus.ack = 1'b1; dbus.rdata = 32'h00008000;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.be !== 4'b0010) begin errors++; $display("FAIL lb_be got %b exp 0010", dbus.be); end
    next_cycle();
    dbus.ack = 1'b0; dbus.rdata = 32'h0;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b0) begin errors++; $display("FAIL done_noreq got %b exp 0", dbus.req); end
    checks++; if (wb_wd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got %h exp ffffff80", wb_wd); end
    next_cycle();
    set_op(LBU, 32'h001, 32'h0, 1'b1);
    dbus.ack = 1'b1; dbus.rdata = 32'h00008000;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b1) begin errors++; $display("FAIL b2b_req got %b exp 1", dbus.req); end
    next_cycle();
    dbus.ack = 1'b0;
    @(negedge cpu_clk_50M);
    checks++; if (wb_wd !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got %h exp 00000080", wb_wd); end
    next_cycle();
    set_op(LH, 32'h002, 32'h0, 1'b1);
    dbus.ack = 1'b1; dbus.rdata = 32'h80010000;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b exp 1100", dbus.be); end
    next_cycle();
    dbus.ack = 1'b0;
    @(negedge cpu_clk_50M);
    checks++; if (wb_wd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sext got %h exp ffff8001", wb_wd); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_misaligned;
`ifdef MEM_ADDR_EXC_EN
    set_op(LW, 32'h102, 32'h0, 1'b1);
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b0 || stall_req !== 1'b0) begin errors++;
      $display("FAIL adel_noreq got req=%b stall=%b exp 0/0", dbus.req, stall_req); end
    checks++; if (wb_exccode !== EXC_ADEL || wb_badvaddr !== 32'h102) begin errors++;
      $display("FAIL adel_exc got exc=%h bad=%h exp %h/102", wb_exccode, wb_badvaddr, EXC_ADEL); end
    checks++; if (wb_wreg !== 1'b0) begin errors++; $display("FAIL adel_wreg got %b exp 0", wb_wreg); end
    next_cycle();
    set_op(SH, 32'h101, 32'h0, 1'b0);
    @(negedge cpu_clk_50M);
    checks++; if (wb_exccode !== EXC_ADES || dbus.req !== 1'b0) begin errors++;
      $display("FAIL ades_exc got exc=%h req=%b exp %h/0", wb_exccode, dbus.req, EXC_ADES); end
    next_cycle();
`else
    set_op(LW, 32'h102, 32'h0, 1'b1);
    dbus.ack = 1'b1; dbus.rdata = 32'h11223344;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b1 || dbus.addr !== 32'h100 || dbus.be !== 4'hF) begin errors++;
      $display("FAIL lw_mask got req=%b addr=%h be=%h exp 1/100/f", dbus.req, dbus.addr, dbus.be); end
    next_cycle();
    dbus.ack = 1'b0;
    @(negedge cpu_clk_50M);
    checks++; if (wb_wd !== 32'h11223344 || wb_exccode !== EXC_NONE) begin errors++;
      $display("FAIL lw_mask_data got wd=%h exc=%h exp 11223344/%h", wb_wd, wb_exccode, EXC_NONE); end
    next_cycle();
    set_op(SH, 32'h101, 32'h0000ABCD, 1'b0);
    dbus.ack = 1'b1;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.be !== 4'b0011 || dbus.wdata !== 32'hABCDABCD) begin errors++;
      $display("FAIL sh_mask got be=%b wdata=%h exp 0011/abcdabcd", dbus.be, dbus.wdata); end
    next_cycle();
    dbus.ack = 1'b0;
    next_cycle();
`endif
    clear_inputs();
  endtask

  task automatic test_flush_wait;
    set_op(LW, 32'h300, 32'h0, 1'b1);
    next_cycle();
    flush = 1'b1;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b1 || stall_req !== 1'b0) begin errors++;
      $display("FAIL flush_hold got req=%b stall=%b exp 1/0", dbus.req, stall_req); end
    next_cycle();
    flush = 1'b0;
    set_op(NOP, 32'h500, 32'h0, 1'b1);
    dbus.ack = 1'b1; dbus.rdata = 32'h00000055;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b1 || dbus.addr !== 32'h300) begin errors++;
      $display("FAIL flush_addr got req=%b addr=%h exp 1/300", dbus.req, dbus.addr); end
    next_cycle();
    dbus.ack = 1'b0;
    @(negedge cpu_clk_50M);
    checks++; if (wb_wreg !== 1'b0 || dbus.req !== 1'b0) begin errors++;
      $display("FAIL flush_kill got wreg=%b req=%b exp 0/0", wb_wreg, dbus.req); end
    next_cycle();
    set_op(LW, 32'h44, 32'h0, 1'b1);
    dbus.ack = 1'b1; dbus.rdata = 32'h13579BDF;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b1 || dbus.addr !== 32'h44) begin errors++;
      $display("FAIL after_flush_req got req=%b addr=%h exp 1/44", dbus.req, dbus.addr); end
    next_cycle();
    dbus.ack = 1'b0;
    @(negedge cpu_clk_50M);
    checks++; if (wb_wreg !== 1'b1 || wb_wd !== 32'h13579BDF) begin errors++;
      $display("FAIL after_flush_wb got wreg=%b wd=%h exp 1/13579bdf", wb_wreg, wb_wd); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_bus_error;
    set_op(SW, 32'h40, 32'hCAFEF00D, 1'b0);
    mem_cp0_we = 1'b1;
    dbus.ack = 1'b1; dbus.err = 1'b1;
    @(negedge cpu_clk_50M);
    checks++; if (dbus.we !== 1'b1 || dbus.be !== 4'hF || dbus.wdata !== 32'hCAFEF00D) begin errors++;
      $display("FAIL sw_issue got we=%b be=%h wdata=%h exp 1/f/cafef00d", dbus.we, dbus.be, dbus.wdata); end
    next_cycle();
    dbus.ack = 1'b0; dbus.err = 1'b0;
    @(negedge cpu_clk_50M);
    checks++; if (wb_exccode !== EXC_BUS || wb_badvaddr !== 32'h40) begin errors++;
      $display("FAIL buserr got exc=%h bad=%h exp %h/40", wb_exccode, wb_badvaddr, EXC_BUS); end
    checks++; if (wb_cp0_we !== 1'b0) begin errors++; $display("FAIL buserr_cp0we got %b exp 0", wb_cp0_we); end
    next_cycle();
    clear_inputs();
    @(negedge cpu_clk_50M);
    checks++; if (wb_exccode !== EXC_NONE) begin errors++; $display("FAIL buserr_leak got %h exp %h", wb_exccode, EXC_NONE); end
    next_cycle();
  endtask

  task automatic test_reset_mid;
    set_op(LW, 32'h80, 32'h0, 1'b1);
    next_cycle();
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b1) begin errors++; $display("FAIL mid_wait_req got %b exp 1", dbus.req); end
    next_cycle();
    cpu_rst = 1'b1;
    next_cycle();
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b exp 0", dbus.req); end
    next_cycle();
    cpu_rst = 1'b0;
    clear_inputs();
    @(negedge cpu_clk_50M);
    checks++; if (dbus.req !== 1'b0 || stall_req !== 1'b0) begin errors++;
      $display("FAIL mid_rst_idle got req=%b stall=%b exp 0/0", dbus.req, stall_req); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_sb_zero_wait();
    test_back_to_back();
    test_misaligned();
    test_flush_wait();
    test_bus_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
